rtc_bus_sequencer: RTL and testbench

- Controller for the multiplexed address/data bus of the external RTC. Sequences the local time/timer register bank through that bus.
- On request, walks a contiguous range of bank indices. For each index it runs one address phase and one data phase on the RTC bus.
- Read sequence: captures RTC data and loads it into the bank. Write sequence: drives bank contents out to the RTC.
- Sits between the user/FSM layer (which issues start_read/start_write) and the bank mux/tri-state bus driver.

---
 rtl/rtc_bus_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for the external RTC.
// Walks a contiguous range of bank indices, one address phase and one data phase per index.
module rtc_bus_sequencer #(
  parameter int T_STROBE = 4,
  parameter int T_GAP    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_read,
  input  logic       start_write,
  input  logic [3:0] reg_first,
  input  logic [3:0] reg_last,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] bank_addr,
  output logic       bank_wr_en,
  output logic [7:0] rd_data,
  input  logic [7:0] wr_data,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  typedef enum logic [2:0] {
    IDLE, ADDR_SU, ADDR_STB, ADDR_HOLD, DATA_SU, DATA_STB, DATA_HOLD, DONE
  } state_t;

  localparam logic [3:0] STB_LAST = 4'(T_STROBE - 1);
  localparam logic [3:0] GAP_LAST = 4'(T_GAP - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [3:0] idx;
  logic [3:0] last_q;
  logic       dir_wr;

  logic req, bad, accept, stb_end, gap_end;

  assign req     = start_read | start_write;
  assign bad     = (reg_first > reg_last) || (reg_last > 4'd10);
  assign accept  = (state == IDLE) && req && !bad;
  assign stb_end = (cnt == STB_LAST);
  assign gap_end = (cnt == GAP_LAST);

  function automatic logic [7:0] rtc_addr(input logic [3:0] i);
    logic [7:0] a;
    a = 8'h00;
    if (i <= 4'd6)
      a = 8'h21 + {4'h0, i};
    else if (i <= 4'd9)
      a = 8'h41 + {4'h0, i} - 8'd7;
    return a;
  endfunction

  // State register, phase counter and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx    <= 4'd0;
      last_q <= 4'd0;
      dir_wr <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
      if (accept) begin
        idx    <= reg_first;
        last_q <= reg_last;
        dir_wr <= start_write;
      end else if (state == DATA_HOLD && gap_end && idx != last_q) begin
        idx <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept) state_nx = ADDR_SU;
      ADDR_SU:   state_nx = ADDR_STB;
      ADDR_STB:  if (stb_end) state_nx = ADDR_HOLD;
      ADDR_HOLD: if (gap_end) state_nx = DATA_SU;
      DATA_SU:   state_nx = DATA_STB;
      DATA_STB:  if (stb_end) state_nx = DATA_HOLD;
      DATA_HOLD: if (gap_end) state_nx = (idx == last_q) ? DONE : ADDR_SU;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Next-cycle output values; every pin is registered below, one cycle behind the state
  logic       busy_d, done_d, error_d, bank_wr_en_d, bus_oe_d, cs_n_d, rd_n_d, wr_n_d, a_d_d;
  logic [7:0] bus_out_d;

  always_comb begin
    busy_d       = (state != IDLE);
    done_d       = 1'b0;
    error_d      = (state == IDLE) && req && bad;
    bank_wr_en_d = 1'b0;
    bus_oe_d     = 1'b0;
    bus_out_d    = bus_out;
    cs_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    wr_n_d       = 1'b1;
    a_d_d        = 1'b0;
    case (state)
      ADDR_SU, ADDR_HOLD: begin
        bus_oe_d  = 1'b1;
        bus_out_d = rtc_addr(idx);
      end
      ADDR_STB: begin
        bus_oe_d  = 1'b1;
        bus_out_d = rtc_addr(idx);
        cs_n_d    = 1'b0;
        wr_n_d    = 1'b0;
      end
      DATA_SU: begin
        a_d_d    = 1'b1;
        bus_oe_d = dir_wr;
        if (dir_wr) bus_out_d = wr_data;
      end
      DATA_STB: begin
        a_d_d    = 1'b1;
        cs_n_d   = 1'b0;
        bus_oe_d = dir_wr;
        wr_n_d   = !dir_wr;
        rd_n_d   = dir_wr;
      end
      DATA_HOLD: begin
        a_d_d        = 1'b1;
        bus_oe_d     = dir_wr;
        bank_wr_en_d = !dir_wr && (cnt == 4'd0);
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // rd_data is sampled on the edge that closes the last visible read-strobe cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      bank_addr  <= 4'd0;
      bank_wr_en <= 1'b0;
      rd_data    <= 8'h00;
      bus_out    <= 8'h00;
      bus_oe     <= 1'b0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      a_d        <= 1'b0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      bank_addr  <= idx;
      bank_wr_en <= bank_wr_en_d;
      bus_out    <= bus_out_d;
      bus_oe     <= bus_oe_d;
      cs_n       <= cs_n_d;
      rd_n       <= rd_n_d;
      wr_n       <= wr_n_d;
      a_d        <= a_d_d;
      if (state == DATA_HOLD && cnt == 4'd0 && !dir_wr)
        rd_data <= bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: RTC bus model, bank model and a request table.
module tb_rtc_bus_sequencer;
  localparam int TS = 4;
  localparam int TG = 2;
  localparam int L  = 2*TS + 2*TG + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_read = 1'b0, start_write = 1'b0;
  logic [3:0] reg_first = 4'd0, reg_last = 4'd0;
  logic       busy, done, error, bank_wr_en, bus_oe, cs_n, rd_n, wr_n, a_d;
  logic [3:0] bank_addr;
  logic [7:0] rd_data, wr_data, bus_in, bus_out;

  always #5 clk = ~clk;

  rtc_bus_sequencer #(.T_STROBE(TS), .T_GAP(TG)) dut (
    .clk(clk), .reset(reset), .start_read(start_read), .start_write(start_write),
    .reg_first(reg_first), .reg_last(reg_last), .busy(busy), .done(done), .error(error),
    .bank_addr(bank_addr), .bank_wr_en(bank_wr_en), .rd_data(rd_data), .wr_data(wr_data),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .a_d(a_d)
  );

  // RTC register file and local bank, both owned by the monitor process
  logic [7:0]  rtc_mem [256];
  logic [7:0]  bank [16];
  logic [7:0]  last_addr = 8'h00;
  logic [7:0]  addr_q [$];
  logic [15:0] wlog_q [$];
  logic [11:0] bwe_q [$];
  int          rd_low_cnt = 0;
  int          viol = 0;

  assign bus_in  = rtc_mem[last_addr];
  assign wr_data = bank[bank_addr];

  initial begin
    logic prev_astb, prev_dstb;
    prev_astb = 1'b0;
    prev_dstb = 1'b0;
    for (int a = 0; a < 256; a++) rtc_mem[a] = 8'(a) ^ 8'h78;
    for (int i = 0; i < 16; i++) bank[i] = 8'(3*i + 1);
    bank[7] = 8'h30; bank[8] = 8'h15; bank[9] = 8'h02;
    forever begin
      @(negedge clk);
      if (!cs_n && rd_n && wr_n) viol++;
      if (!rd_n && !wr_n) viol++;
      if (bus_oe && !rd_n) viol++;
      if (!rd_n) rd_low_cnt++;
      if (!cs_n && !wr_n && !a_d && !prev_astb) begin
        last_addr = bus_out;
        addr_q.push_back(bus_out);
      end
      if (!cs_n && !wr_n && a_d && !prev_dstb) begin
        rtc_mem[last_addr] = bus_out;
        wlog_q.push_back({last_addr, bus_out});
      end
      prev_astb = !cs_n && !wr_n && !a_d;
      prev_dstb = !cs_n && !wr_n && a_d;
      if (bank_wr_en) begin
        bank[bank_addr] = rd_data;
        bwe_q.push_back({bank_addr, rd_data});
      end
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  function automatic int map_addr(input int i);
    case (i)
      0: return 'h21;  1: return 'h22;  2: return 'h23;  3: return 'h24;
      4: return 'h25;  5: return 'h26;  6: return 'h27;
      7: return 'h41;  8: return 'h42;  9: return 'h43;
      default: return 'h00;
    endcase
  endfunction

  typedef struct {
    logic       sr;
    logic       sw;
    logic [3:0] first;
    logic [3:0] last;
    logic       exp_err;
    logic       exp_wr;
    int         exp_n;
  } vec_t;

  task automatic run_req(input int id, input vec_t v);
    int a0, w0, b0, r0, done_m, err_m, busy_seen, lim;
    logic [7:0] sb [11];
    logic [7:0] sr [11];
    string p;
    p = $sformatf("v%0d", id);
    for (int i = 0; i < 11; i++) begin
      sb[i] = bank[i];
      sr[i] = rtc_mem[map_addr(i)];
    end
    a0 = addr_q.size(); w0 = wlog_q.size(); b0 = bwe_q.size(); r0 = rd_low_cnt;
    @(negedge clk);
    start_read = v.sr; start_write = v.sw; reg_first = v.first; reg_last = v.last;
    @(posedge clk);
    #1;
    start_read = 1'b0; start_write = 1'b0; reg_first = 4'hF; reg_last = 4'hF;
    done_m = -1; err_m = -1; busy_seen = 0;
    lim = v.exp_err ? 20 : v.exp_n * L + 10;
    for (int m = 0; m < lim; m++) begin
      @(negedge clk);
      if (done && done_m < 0) done_m = m;
      if (error && err_m < 0) err_m = m;
      if (busy) busy_seen = 1;
      if (done_m >= 0 && m > done_m + 1) break;
    end
    if (v.exp_err) begin
      chk({p, "_err_cycle"}, err_m, 0);
      chk({p, "_err_busy"}, busy_seen, 0);
      chk({p, "_err_nodone"}, done_m, -1);
      chk({p, "_err_nobus"}, addr_q.size() - a0, 0);
    end else begin
      chk({p, "_done_lat"}, done_m, 1 + v.exp_n * L);
      chk({p, "_no_err"}, err_m, -1);
      chk({p, "_addr_cnt"}, addr_q.size() - a0, v.exp_n);
      for (int i = 0; i < v.exp_n && a0 + i < addr_q.size(); i++)
        chk({p, "_addr"}, int'(addr_q[a0 + i]), map_addr(int'(v.first) + i));
      if (v.exp_wr) begin
        chk({p, "_wlog_cnt"}, wlog_q.size() - w0, v.exp_n);
        for (int i = 0; i < v.exp_n && w0 + i < wlog_q.size(); i++)
          chk({p, "_wlog"}, int'(wlog_q[w0 + i]),
              (map_addr(int'(v.first) + i) << 8) | int'(sb[int'(v.first) + i]));
        chk({p, "_rd_low"}, rd_low_cnt - r0, 0);
        chk({p, "_bwe_cnt"}, bwe_q.size() - b0, 0);
      end else begin
        chk({p, "_bwe_cnt"}, bwe_q.size() - b0, v.exp_n);
        for (int i = 0; i < v.exp_n && b0 + i < bwe_q.size(); i++)
          chk({p, "_bwe"}, int'(bwe_q[b0 + i]),
              ((int'(v.first) + i) << 8) | int'(sr[int'(v.first) + i]));
        chk({p, "_rd_low"}, rd_low_cnt - r0, TS * v.exp_n);
        chk({p, "_wlog_cnt"}, wlog_q.size() - w0, 0);
      end
    end
    chk({p, "_busy_after"}, int'(busy), 0);
  endtask

  vec_t vecs [9];

  initial begin
    int bad, b0;
    vec_t v;
    vecs[0] = '{sr:1, sw:0, first:0,  last:0,  exp_err:0, exp_wr:0, exp_n:1};
    vecs[1] = '{sr:0, sw:1, first:7,  last:9,  exp_err:0, exp_wr:1, exp_n:3};
    vecs[2] = '{sr:1, sw:1, first:4,  last:4,  exp_err:0, exp_wr:1, exp_n:1};
    vecs[3] = '{sr:1, sw:0, first:5,  last:3,  exp_err:1, exp_wr:0, exp_n:0};
    vecs[4] = '{sr:0, sw:1, first:0,  last:11, exp_err:1, exp_wr:0, exp_n:0};
    vecs[5] = '{sr:1, sw:0, first:7,  last:10, exp_err:0, exp_wr:0, exp_n:4};
    vecs[6] = '{sr:0, sw:1, first:10, last:10, exp_err:0, exp_wr:1, exp_n:1};
    vecs[7] = '{sr:1, sw:0, first:0,  last:6,  exp_err:0, exp_wr:0, exp_n:7};
    vecs[8] = '{sr:1, sw:0, first:8,  last:7,  exp_err:1, exp_wr:0, exp_n:0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulses", int'({done, error, bank_wr_en}), 0);
    chk("rst_strobes", int'({cs_n, rd_n, wr_n}), 7);
    chk("rst_bus", int'({bus_oe, a_d, bus_out, rd_data, bank_addr}), 0);

    // Idle with reset released
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!cs_n || !rd_n || !wr_n || bus_oe || busy || done || error || bank_wr_en) bad++;
    end
    chk("idle_quiet", bad, 0);

    for (int i = 0; i < 9; i++) run_req(i, vecs[i]);

    // Reset in the middle of a 0..6 read
    b0 = bwe_q.size();
    @(negedge clk);
    start_read = 1'b1; reg_first = 4'd0; reg_last = 4'd6;
    @(posedge clk);
    #1;
    start_read = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_strobes", int'({cs_n, rd_n, wr_n}), 7);
    chk("midrst_oe", int'(bus_oe), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_bwe", bwe_q.size() - b0, 0);
    chk("midrst_idle", int'(busy), 0);

    v = '{sr:1, sw:0, first:2, last:3, exp_err:0, exp_wr:0, exp_n:2};
    run_req(9, v);

    chk("strobe_invariants", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
